byte_serializer_1mhz: RTL and testbench

- Parallel-to-serial transmit stage downstream of the 1 MHz clock conditioner.
- Runs entirely on CLK and treats the conditioned CLK_1Mhz as a synchronous bit-rate strobe.
- Shifts one bit per CLK_1Mhz rising edge, MSB first.
- After reset, sends a fixed training run of COM symbols. Then serializes bytes offered through a valid/ready handshake, and fills every gap with the idle symbol.

---
 rtl/byte_serializer_1mhz.sv | 131 +++++++++++++
 tb/tb_byte_serializer_1mhz.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/byte_serializer_1mhz.sv
// rtl/byte_serializer_1mhz.sv - MSB-first byte serializer paced by a 1 MHz bit strobe, with COM training and idle fill
module byte_serializer_1mhz #(
    parameter int                DATA_W     = 8,
    parameter logic [DATA_W-1:0] IDLE_SYM   = DATA_W'(8'hBC),
    parameter int                TRAIN_SYMS = 4
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              CLK_1Mhz,
    input  logic [DATA_W-1:0] DATA_IN,
    input  logic              DATA_VALID,
    output logic              READY,
    output logic              SER_OUT,
    output logic              SER_IS_DATA,
    output logic              SER_SOS,
    output logic              TRAINED
);

    localparam int CNT_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int TRAIN_W = $clog2(TRAIN_SYMS + 1);

    typedef enum logic {
        S_TRAIN  = 1'b0,
        S_ACTIVE = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic                r_prev_1mhz;
    logic [CNT_W-1:0]    r_bit_cnt;
    logic [DATA_W-1:0]   r_hold;
    logic                r_hold_full;
    logic [TRAIN_W-1:0]  r_train_cnt;
    logic [DATA_W-2:0]   r_shift;
    logic                r_ser_out;
    logic                r_is_data;
    logic                r_sos;
    logic                r_trained;

    logic                w_tick;
    logic                w_boundary;
    logic                w_accept;
    logic                w_load_data;
    logic [DATA_W-1:0]   w_symbol;

    // CLK_1Mhz is already synchronous to CLK, so a single delay stage is enough for edge detection
    assign w_tick     = CLK_1Mhz & ~r_prev_1mhz;
    assign w_boundary = w_tick && (r_bit_cnt == '0);
    assign READY      = RESET & (r_state == S_ACTIVE) & ~r_hold_full;
    assign w_accept   = DATA_VALID & READY;

    always_comb begin
        w_state_next = r_state;
        w_load_data  = 1'b0;
        w_symbol     = IDLE_SYM;
        case (r_state)
            S_TRAIN: begin
                if (w_boundary && (r_train_cnt == TRAIN_W'(TRAIN_SYMS - 1))) begin
                    w_state_next = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                // Load sees the hold state from before this edge; a same-cycle accept waits a symbol
                if (w_boundary && r_hold_full) begin
                    w_load_data = 1'b1;
                    w_symbol    = r_hold;
                end
            end
            default: w_state_next = S_TRAIN;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state     <= S_TRAIN;
            r_prev_1mhz <= 1'b0;
            r_bit_cnt   <= '0;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_train_cnt <= '0;
            r_shift     <= '0;
            r_ser_out   <= 1'b0;
            r_is_data   <= 1'b0;
            r_sos       <= 1'b0;
            r_trained   <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_prev_1mhz <= CLK_1Mhz;

            if (w_tick) begin
                if (r_bit_cnt == CNT_W'(DATA_W - 1)) begin
                    r_bit_cnt <= '0;
                end else begin
                    r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                end
            end

            if (w_boundary) begin
                r_ser_out <= w_symbol[DATA_W-1];
                r_shift   <= w_symbol[DATA_W-2:0];
                r_sos     <= 1'b1;
                r_is_data <= w_load_data;
            end else if (w_tick) begin
                r_ser_out <= r_shift[DATA_W-2];
                r_shift   <= r_shift << 1;
                r_sos     <= 1'b0;
            end

            if (w_accept) begin
                r_hold      <= DATA_IN;
                r_hold_full <= 1'b1;
            end else if (w_load_data) begin
                r_hold_full <= 1'b0;
            end

            if ((r_state == S_TRAIN) && w_boundary) begin
                r_train_cnt <= r_train_cnt + TRAIN_W'(1);
            end

            if ((r_state == S_TRAIN) && (w_state_next == S_ACTIVE)) begin
                r_trained <= 1'b1;
            end
        end
    end

    assign SER_OUT     = r_ser_out;
    assign SER_IS_DATA = r_is_data;
    assign SER_SOS     = r_sos;
    assign TRAINED     = r_trained;

endmodule

// File: tb/tb_byte_serializer_1mhz.sv
// tb/tb_byte_serializer_1mhz.sv - scoreboard bench for byte_serializer_1mhz
module tb_byte_serializer_1mhz;

    localparam int         TRAIN = 4;
    localparam logic [7:0] IDLE  = 8'hBC;

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic       CLK_1Mhz = 1'b0;
    logic [7:0] DATA_IN = 8'h00;
    logic       DATA_VALID = 1'b0;
    logic       READY, SER_OUT, SER_IS_DATA, SER_SOS, TRAINED;

    byte_serializer_1mhz #(
        .DATA_W(8),
        .IDLE_SYM(8'hBC),
        .TRAIN_SYMS(TRAIN)
    ) dut (
        .CLK(CLK),
        .RESET(RESET),
        .CLK_1Mhz(CLK_1Mhz),
        .DATA_IN(DATA_IN),
        .DATA_VALID(DATA_VALID),
        .READY(READY),
        .SER_OUT(SER_OUT),
        .SER_IS_DATA(SER_IS_DATA),
        .SER_SOS(SER_SOS),
        .TRAINED(TRAINED)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_fail = 0;
    int cycle = 0;
    always @(posedge CLK) cycle <= cycle + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic flag_fail(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Bit-rate divider: high 2 CLK, low 2 CLK, freezable
    int div_cnt = 0;
    bit div_en = 1'b1;
    initial forever begin
        @(negedge CLK);
        if (div_en) begin
            div_cnt  = (div_cnt + 1) % 4;
            CLK_1Mhz = (div_cnt < 2);
        end
    end

    // Bench's own view of when a new bit appears on the line
    logic tb_prev = 1'b0;
    logic tb_tick = 1'b0;
    always @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            tb_prev <= 1'b0;
            tb_tick <= 1'b0;
        end else begin
            tb_tick <= CLK_1Mhz & ~tb_prev;
            tb_prev <= CLK_1Mhz;
        end
    end

    typedef struct {
        logic [7:0] sym;
        logic       isd;
        int         cyc;
    } sym_t;

    sym_t       sym_log[$];
    logic [7:0] exp_q[$];
    int         m_cnt = 0;
    int         m_sos_count = 0;
    logic [7:0] m_sym = 8'h00;
    logic       m_isd = 1'b0;
    int         m_sos_cyc = 0;

    // Monitor: reassemble symbols from the serial line and score them
    initial forever begin
        @(negedge CLK);
        if (!RESET) begin
            m_cnt = 0;
            m_sos_count = 0;
            sym_log.delete();
        end else begin
            if (READY) check("ready_only_when_trained", TRAINED, 1);
            if (tb_tick) begin
                check("sos_position", SER_SOS, (m_cnt == 0));
                if (m_cnt == 0) begin
                    m_sym = {7'b0, SER_OUT};
                    m_isd = SER_IS_DATA;
                    m_sos_cyc = cycle;
                    m_sos_count++;
                    check("trained_at_sos", TRAINED, (m_sos_count >= TRAIN));
                    if (m_sos_count <= TRAIN) check("training_is_idle", SER_IS_DATA, 0);
                end else begin
                    m_sym = {m_sym[6:0], SER_OUT};
                    check("is_data_stable", SER_IS_DATA, m_isd);
                end
                m_cnt++;
                if (m_cnt == 8) begin
                    m_cnt = 0;
                    if (m_isd) begin
                        if (exp_q.size() == 0) flag_fail("unexpected_data_symbol");
                        else check("data_symbol", m_sym, exp_q.pop_front());
                    end else begin
                        check("idle_symbol", m_sym, IDLE);
                    end
                    sym_log.push_back('{m_sym, m_isd, m_sos_cyc});
                end
            end
        end
    end

    task automatic send(input logic [7:0] b, input int budget);
        bit got;
        got = 0;
        DATA_IN = b;
        DATA_VALID = 1'b1;
        for (int i = 0; i < budget && !got; i++) begin
            if (READY) begin
                exp_q.push_back(b);
                check("accept_when_trained", TRAINED, 1);
                got = 1;
            end
            @(negedge CLK);
        end
        if (!got) flag_fail("timeout_send");
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge CLK);
        if (exp_q.size() != 0) flag_fail("timeout_drain");
    endtask

    task automatic wait_symbols(input int n, input int budget);
        int start;
        start = sym_log.size();
        for (int i = 0; i < budget && sym_log.size() < start + n; i++) @(negedge CLK);
        if (sym_log.size() < start + n) flag_fail("timeout_symbols");
    endtask

    task automatic wait_trained(input int budget);
        for (int i = 0; i < budget && !TRAINED; i++) @(negedge CLK);
        if (!TRAINED) flag_fail("timeout_trained");
    endtask

    task automatic wait_bitpos(input int pos, input int budget);
        bit hit;
        hit = 0;
        for (int i = 0; i < budget && !hit; i++) begin
            @(negedge CLK);
            if (m_isd && m_cnt == pos) hit = 1;
        end
        if (!hit) flag_fail("timeout_bitpos");
    endtask

    task automatic apply_reset();
        @(posedge CLK);
        #3 RESET = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge CLK);
        @(posedge CLK);
        #2 RESET = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int   base;
        int   k;
        int   gap;
        logic so;
        logic ss;

        repeat (3) @(negedge CLK);
        check("reset_ser_out", SER_OUT, 0);
        check("reset_is_data", SER_IS_DATA, 0);
        check("reset_sos", SER_SOS, 0);
        check("reset_trained", TRAINED, 0);
        check("reset_ready", READY, 0);

        @(posedge CLK);
        #2 RESET = 1'b1;
        wait_trained(300);
        check("ready_after_trained", READY, 1);
        wait_symbols(3, 200);
        check("ready_idle", READY, 1);

        // Single byte pulse
        send(8'hA5, 100);
        DATA_VALID = 1'b0;
        check("ready_drop", READY, 0);
        wait_drain(200);
        wait_symbols(1, 100);
        check("after_data_isd", sym_log[sym_log.size()-1].isd, 0);
        check("after_data_sym", sym_log[sym_log.size()-1].sym, IDLE);
        check("ready_return", READY, 1);

        // Back-to-back streaming
        base = sym_log.size();
        send(8'h01, 100);
        send(8'hFF, 100);
        DATA_VALID = 1'b0;
        wait_drain(300);
        k = -1;
        for (int i = base; i < sym_log.size(); i++)
            if (k < 0 && sym_log[i].isd && sym_log[i].sym == 8'h01) k = i;
        if (k >= 0 && k + 1 < sym_log.size()) begin
            check("b2b_second_isd", sym_log[k+1].isd, 1);
            check("b2b_second_sym", sym_log[k+1].sym, 8'hFF);
            check("b2b_sos_spacing", sym_log[k+1].cyc - sym_log[k].cyc, 32);
        end else begin
            flag_fail("b2b_pair_missing");
        end

        // Data offered during training
        apply_reset();
        send(8'h3C, 400);
        DATA_VALID = 1'b0;
        wait_drain(200);
        if (sym_log.size() >= 5) begin
            for (int i = 0; i < TRAIN; i++) check("train_then_idle", sym_log[i].isd, 0);
            check("first_data_isd", sym_log[TRAIN].isd, 1);
            check("first_data_sym", sym_log[TRAIN].sym, 8'h3C);
        end else begin
            flag_fail("first_data_missing");
        end

        // Randomized traffic
        for (int n = 0; n < 30; n++) begin
            gap = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 40);
            if (gap > 0) begin
                DATA_VALID = 1'b0;
                repeat (gap) @(negedge CLK);
            end
            send(8'($urandom_range(0, 255)), 200);
        end
        DATA_VALID = 1'b0;
        wait_drain(400);

        // Bit strobe stuck low mid-byte
        send(8'hA5, 100);
        DATA_VALID = 1'b0;
        wait_bitpos(3, 200);
        div_en = 1'b0;
        CLK_1Mhz = 1'b0;
        so = SER_OUT;
        ss = SER_SOS;
        repeat (20) begin
            @(negedge CLK);
            check("freeze_ser_out", SER_OUT, so);
            check("freeze_sos", SER_SOS, ss);
            check("freeze_bitpos", m_cnt, 3);
        end
        div_cnt = 3;
        div_en = 1'b1;
        wait_drain(200);

        // Asynchronous reset in the middle of a data byte
        send(8'hA5, 100);
        DATA_VALID = 1'b0;
        wait_bitpos(5, 200);
        @(posedge CLK);
        #3 RESET = 1'b0;
        exp_q.delete();
        #1;
        check("async_ser_out", SER_OUT, 0);
        check("async_is_data", SER_IS_DATA, 0);
        check("async_sos", SER_SOS, 0);
        check("async_trained", TRAINED, 0);
        check("async_ready", READY, 0);
        repeat (2) @(negedge CLK);
        @(posedge CLK);
        #2 RESET = 1'b1;
        wait_trained(300);
        wait_symbols(6, 300);
        if (sym_log.size() >= 6) begin
            for (int i = 0; i < 6; i++) check("retrain_idle", sym_log[i].isd, 0);
        end else begin
            flag_fail("retrain_missing");
        end

        check("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
